// File: rtl/enc_dec_pkg.sv
// Shared encodings, FSM states and SECDED helper functions for enc_dec_engine.
// Codewords are at most 32 bits (k=26, m=5), so the helpers work on 32-bit vectors.
package enc_dec_pkg;

  typedef enum logic [1:0] {
    MODE_ENC  = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_FULL = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENCODE  = 3'd1,
    ST_CORRUPT = 3'd2,
    ST_DECODE  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int CW_MAX = 32;

  function automatic int m_of(input logic [1:0] width);
    int m;
    case (width)
      2'b00:   m = 3;
      2'b01:   m = 4;
      default: m = 5;
    endcase
    return m;
  endfunction

  function automatic int k_of(input logic [1:0] width);
    return (1 << m_of(width)) - m_of(width) - 1;
  endfunction

  function automatic int n_of(input logic [1:0] width);
    return k_of(width) + m_of(width) + 1;
  endfunction

  function automatic logic [31:0] mask_of(input int bits);
    logic [31:0] mask;
    if (bits >= CW_MAX) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'h1 << bits) - 32'h1;
    end
    return mask;
  endfunction

  // H-column of codeword bit b; the overall-parity bit (and beyond) has column 0.
  function automatic logic [4:0] h_col(input int b, input int m);
    int k;
    int idx;
    logic [4:0] col;
    k   = (1 << m) - m - 1;
    idx = 0;
    col = 5'd0;
    if (b >= k && b < k + m) begin
      col = 5'(1 << (b - k));
    end else if (b < k) begin
      for (int v = 3; v < CW_MAX; v++) begin
        if ((v & (v - 1)) != 0) begin
          if (idx == b) begin
            col = 5'(v);
          end else begin
            col = col;
          end
          idx = idx + 1;
        end else begin
          idx = idx;
        end
      end
    end else begin
      col = 5'd0;
    end
    return col;
  endfunction

  function automatic logic [31:0] encode(input logic [31:0] info, input logic [1:0] width);
    int m;
    int k;
    int n;
    logic [31:0] cw;
    logic [4:0] col;
    logic p;
    m  = m_of(width);
    k  = k_of(width);
    n  = n_of(width);
    cw = info & mask_of(k);
    for (int j = 0; j < 5; j++) begin
      if (j < m) begin
        p = 1'b0;
        for (int i = 0; i < 26; i++) begin
          col = h_col(i, m);
          p   = p ^ (i < k && cw[i] && col[j]);
        end
        cw[k + j] = p;
      end else begin
        p = 1'b0;
      end
    end
    cw[n - 1] = ^cw;
    return cw;
  endfunction

endpackage

// File: rtl/enc_dec_engine_if.sv
// Register-side bundle between the APB register selector (master) and enc_dec_engine (slave).
// ERR_COUNT exists only when ENC_DEC_ERR_CNT_EN is defined.
interface enc_dec_engine_if #(
  parameter int AMBA_WORD = 32
) ();

  logic                 start;
  logic [AMBA_WORD-1:0] CTRL;
  logic [AMBA_WORD-1:0] DATA_IN;
  logic [AMBA_WORD-1:0] CODEWORD_WIDTH;
  logic [AMBA_WORD-1:0] NOISE;
  logic [AMBA_WORD-1:0] DATA_OUT;
  logic                 OPERATION_DONE;
  logic [1:0]           NUM_OF_ERRORS;
  logic                 BUSY;
`ifdef ENC_DEC_ERR_CNT_EN
  logic [15:0]          ERR_COUNT;

  modport master (output start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE,
                  input  DATA_OUT, OPERATION_DONE, NUM_OF_ERRORS, BUSY, ERR_COUNT);
  modport slave  (input  start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE,
                  output DATA_OUT, OPERATION_DONE, NUM_OF_ERRORS, BUSY, ERR_COUNT);
`else
  modport master (output start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE,
                  input  DATA_OUT, OPERATION_DONE, NUM_OF_ERRORS, BUSY);
  modport slave  (input  start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE,
                  output DATA_OUT, OPERATION_DONE, NUM_OF_ERRORS, BUSY);
`endif

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational SECDED checker: syndrome S and overall-parity mismatch Q of a codeword
// masked to the n bits implied by the selected width.
module hamming_syndrome
  import enc_dec_pkg::*;
(
  input  logic [31:0] cw,
  input  logic [1:0]  width,
  output logic [4:0]  syndrome,
  output logic        overall
);

  int          m_s;
  int          n_s;
  logic [31:0] cw_m_s;
  logic [4:0]  col_s;

  // Syndrome accumulation over every data/parity bit below the overall-parity bit.
  always_comb begin
    m_s      = m_of(width);
    n_s      = n_of(width);
    cw_m_s   = cw & mask_of(n_s);
    col_s    = 5'd0;
    syndrome = 5'd0;
    for (int b = 0; b < CW_MAX - 1; b++) begin
      col_s    = h_col(b, m_s);
      syndrome = syndrome ^ ((b < n_s - 1 && cw_m_s[b]) ? col_s : 5'd0);
    end
    overall = ^cw_m_s;
  end

endmodule

// File: rtl/enc_dec_engine.sv
// Extended-Hamming (SECDED) encode / decode / full-channel engine behind the APB register block.
// Optional ENC_DEC_ERR_CNT_EN adds a saturating double-error counter on ERR_COUNT.
module enc_dec_engine
  import enc_dec_pkg::*;
#(
  parameter int AMBA_WORD = 32
) (
  input  logic             clk,
  input  logic             rst,
  enc_dec_engine_if.slave  bus
);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [1:0]           width_q, width_d;
  logic [31:0]          cw_q, cw_d;
  logic [31:0]          noise_q, noise_d;
  logic [AMBA_WORD-1:0] data_out_q, data_out_d;
  logic [1:0]           nerr_q, nerr_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [4:0]  syn_s;
  logic        ovl_s;
  logic [31:0] enc_cw_s;
  logic [31:0] corr_s;
  logic [31:0] dec_info_s;
  logic [1:0]  dec_err_s;
  logic [4:0]  col_s;
  int          dm_s;
  int          dk_s;
  int          dn_s;
  logic        unused_s;

  assign unused_s = ^{bus.CTRL[AMBA_WORD-1:2], bus.CODEWORD_WIDTH[AMBA_WORD-1:2]};

  hamming_syndrome u_syndrome (
    .cw       (cw_q),
    .width    (width_q),
    .syndrome (syn_s),
    .overall  (ovl_s)
  );

  // Datapath: encoder output and single-error correction of the held codeword.
  always_comb begin
    dm_s     = m_of(width_q);
    dk_s     = k_of(width_q);
    dn_s     = n_of(width_q);
    enc_cw_s = encode(cw_q, width_q);
    corr_s   = cw_q & mask_of(dn_s);
    col_s    = 5'd0;
    if (ovl_s) begin
      // S=0 with Q=1 means the overall-parity bit itself flipped.
      if (syn_s == 5'd0) begin
        corr_s[dn_s - 1] = ~corr_s[dn_s - 1];
      end else begin
        for (int b = 0; b < CW_MAX - 1; b++) begin
          col_s     = h_col(b, dm_s);
          corr_s[b] = corr_s[b] ^ (b < dn_s - 1 && col_s == syn_s);
        end
      end
      dec_err_s = 2'd1;
    end else if (syn_s != 5'd0) begin
      dec_err_s = 2'd2;
    end else begin
      dec_err_s = 2'd0;
    end
    dec_info_s = corr_s & mask_of(dk_s);
  end

  // Next-state, capture and output-register logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    width_d    = width_q;
    cw_d       = cw_q;
    noise_d    = noise_q;
    data_out_d = data_out_q;
    nerr_d     = nerr_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d  = mode_e'(bus.CTRL[1:0]);
          width_d = bus.CODEWORD_WIDTH[1:0];
          cw_d    = bus.DATA_IN[31:0];
          noise_d = bus.NOISE[31:0];
          case (mode_e'(bus.CTRL[1:0]))
            MODE_ENC:  state_d = ST_ENCODE;
            MODE_FULL: state_d = ST_ENCODE;
            MODE_DEC:  state_d = ST_DECODE;
            default: begin
              state_d    = ST_DONE;
              data_out_d = '0;
              nerr_d     = 2'd0;
              done_d     = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENCODE: begin
        cw_d = enc_cw_s;
        if (mode_q == MODE_FULL) begin
          state_d = ST_CORRUPT;
        end else begin
          state_d           = ST_DONE;
          data_out_d        = '0;
          data_out_d[31:0]  = enc_cw_s;
          nerr_d            = 2'd0;
          done_d            = 1'b1;
        end
      end
      ST_CORRUPT: begin
        cw_d    = cw_q ^ (noise_q & mask_of(n_of(width_q)));
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d          = ST_DONE;
        data_out_d       = '0;
        data_out_d[31:0] = dec_info_s;
        nerr_d           = dec_err_s;
        done_d           = 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, capture and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ENC;
      width_q    <= 2'b00;
      cw_q       <= 32'd0;
      noise_q    <= 32'd0;
      data_out_q <= '0;
      nerr_q     <= 2'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      width_q    <= width_d;
      cw_q       <= cw_d;
      noise_q    <= noise_d;
      data_out_q <= data_out_d;
      nerr_q     <= nerr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.DATA_OUT       = data_out_q;
  assign bus.NUM_OF_ERRORS  = nerr_q;
  assign bus.OPERATION_DONE = done_q;
  assign bus.BUSY           = busy_q;

`ifdef ENC_DEC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of completed operations that reported a double error.
  always_comb begin
    if (done_d && nerr_d == 2'd2 && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Double-error counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.ERR_COUNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_enc_dec_engine.sv
// Scoreboard bench for enc_dec_engine: stimulus pushes expected results, a monitor pops on OPERATION_DONE.
// Build with ENC_DEC_ERR_CNT_EN to also cover the double-error counter.
module tb_enc_dec_engine;

  logic clk;
  logic rst;

  enc_dec_engine_if #(.AMBA_WORD(32)) bus ();

  enc_dec_engine #(.AMBA_WORD(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] dout;
    logic [1:0]  nerr;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   done_seen  = 0;
  int   exp_done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bus.OPERATION_DONE) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with DATA_OUT=0x%0h, expected no done", bus.DATA_OUT);
      end else begin
        e = sb.pop_front();
        chk("data_out", bus.DATA_OUT, e.dout);
        chk("num_of_errors", {30'd0, bus.NUM_OF_ERRORS}, {30'd0, e.nerr});
      end
    end
  end

  task automatic drive_regs(input logic [1:0] ctrl, input logic [1:0] w,
                            input logic [31:0] din, input logic [31:0] noise);
    bus.CTRL           = {30'd0, ctrl};
    bus.CODEWORD_WIDTH = {30'd0, w};
    bus.DATA_IN        = din;
    bus.NOISE          = noise;
  endtask

  task automatic run_op(input logic [1:0] ctrl, input logic [1:0] w, input logic [31:0] din,
                        input logic [31:0] noise, input logic [31:0] exp_out,
                        input logic [1:0] exp_err, input int exp_lat);
    int lat;
    sb.push_back('{exp_out, exp_err});
    exp_done++;
    @(negedge clk);
    drive_regs(ctrl, w, din, noise);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    // Scribble the registers after capture; the result must not change.
    drive_regs(~ctrl, ~w, 32'hDEAD_BEEF, 32'h5A5A_A5A5);
    chk("busy_after_start", {31'd0, bus.BUSY}, 32'd1);
    lat = 1;
    while (!bus.OPERATION_DONE && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("done_latency", lat, exp_lat);
    @(negedge clk);
    chk("busy_back_idle", {31'd0, bus.BUSY}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst       = 1'b0;
    bus.start = 1'b0;
    drive_regs(2'b00, 2'b00, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_data_out", bus.DATA_OUT, 32'd0);
    chk("rst_nerr", {30'd0, bus.NUM_OF_ERRORS}, 32'd0);
    chk("rst_done", {31'd0, bus.OPERATION_DONE}, 32'd0);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    rst = 1'b1;

    // ctrl, width, data_in, noise, exp DATA_OUT, exp errors, exp latency
    run_op(2'b00, 2'b00, 32'h0000_0001, 32'h0, 32'h0000_00B1, 2'd0, 2);
    run_op(2'b01, 2'b00, 32'h0000_00B0, 32'h0, 32'h0000_0001, 2'd1, 2);
    run_op(2'b01, 2'b00, 32'h0000_00B2, 32'h0, 32'h0000_0002, 2'd2, 2);
    run_op(2'b10, 2'b10, 32'h03FF_FFFF, 32'h0, 32'h03FF_FFFF, 2'd0, 4);
    run_op(2'b10, 2'b10, 32'h03FF_FFFF, 32'h8000_0000, 32'h03FF_FFFF, 2'd1, 4);
    run_op(2'b11, 2'b00, 32'h0000_00FF, 32'h0, 32'h0000_0000, 2'd0, 1);
    run_op(2'b00, 2'b00, 32'hFFFF_FFF1, 32'h0, 32'h0000_00B1, 2'd0, 2);
    run_op(2'b00, 2'b01, 32'h0000_0001, 32'h0, 32'h0000_9801, 2'd0, 2);
    run_op(2'b01, 2'b01, 32'h0000_9821, 32'h0, 32'h0000_0001, 2'd1, 2);
    run_op(2'b10, 2'b11, 32'h0000_0001, 32'h3, 32'h0000_0002, 2'd2, 4);
    run_op(2'b01, 2'b00, 32'hFFFF_FFB1, 32'h0, 32'h0000_0001, 2'd0, 2);
    run_op(2'b01, 2'b00, 32'h0000_0031, 32'h0, 32'h0000_0001, 2'd1, 2);

    // Second start while busy is ignored: one done, result of the first op.
    base = done_seen;
    sb.push_back('{32'h03FF_FFFF, 2'd0});
    exp_done++;
    @(negedge clk);
    drive_regs(2'b10, 2'b10, 32'h03FF_FFFF, 32'h0);
    bus.start = 1'b1;
    @(negedge clk);
    drive_regs(2'b01, 2'b00, 32'h0000_00B2, 32'h0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_start_ignored", done_seen - base, 1);

    // Start during the DONE cycle is ignored.
    base = done_seen;
    sb.push_back('{32'h0000_00B1, 2'd0});
    exp_done++;
    @(negedge clk);
    drive_regs(2'b00, 2'b00, 32'h1, 32'h0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.OPERATION_DONE && done_seen - base < 1) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("done_start_ignored", done_seen - base, 1);

    // Reset during CORRUPT: outputs clear and the aborted op never completes.
    base = done_seen;
    @(negedge clk);
    drive_regs(2'b10, 2'b10, 32'h0000_0005, 32'h1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_data_out", bus.DATA_OUT, 32'd0);
    chk("abort_nerr", {30'd0, bus.NUM_OF_ERRORS}, 32'd0);
    chk("abort_done", {31'd0, bus.OPERATION_DONE}, 32'd0);
    chk("abort_busy", {31'd0, bus.BUSY}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_seen - base, 0);

    // Three double-error decodes after reset.
    run_op(2'b01, 2'b00, 32'h0000_00B2, 32'h0, 32'h0000_0002, 2'd2, 2);
    run_op(2'b01, 2'b00, 32'h0000_00B2, 32'h0, 32'h0000_0002, 2'd2, 2);
    run_op(2'b01, 2'b00, 32'h0000_00B2, 32'h0, 32'h0000_0002, 2'd2, 2);
`ifdef ENC_DEC_ERR_CNT_EN
    chk("err_count_3", {16'd0, bus.ERR_COUNT}, 32'd3);
    force dut.err_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.err_cnt_q;
    run_op(2'b01, 2'b00, 32'h0000_00B2, 32'h0, 32'h0000_0002, 2'd2, 2);
    chk("err_count_sat", {16'd0, bus.ERR_COUNT}, 32'h0000_FFFF);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("done_total", done_seen, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
